cmos_size_check: RTL and testbench

Checks the OV5640 DVP stream against the configured output size. It runs in the camera pixel-clock domain, between the camera capture front end and the SDRAM write path. After camera configuration finishes and a settling period passes, it measures every frame: pixels per line (bytes/2, RGB565) and lines per frame. It compares both against the expected resolution supplied by the size-selection logic and reports per-frame pass/fail, so a mis-programmed sensor is caught before it can overrun the frame buffer.

---
 rtl/cmos_size_check.sv | 150 +++++++++++++++
 tb/tb_cmos_size_check.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cmos_size_check.sv
// rtl/cmos_size_check.sv - per-frame DVP output size checker for the OV5640 capture path
module cmos_size_check #(
  parameter int SKIP_FRAMES = 10
) (
  input  logic        cam_pclk,
  input  logic        rst_n,
  input  logic        cfg_done,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [12:0] exp_h_pixel,
  input  logic [12:0] exp_v_pixel,
  output logic [12:0] meas_h_pixel,
  output logic [12:0] meas_v_pixel,
  output logic        meas_valid,
  output logic        size_ok,
  output logic        size_err,
  output logic [7:0]  frame_cnt
);

  typedef enum logic [1:0] {IDLE, SKIP, MEAS} state_t;

  localparam logic [15:0] SKIP_LIM = 16'(SKIP_FRAMES);

  state_t      state;
  logic        vsync_d0, vsync_d1, href_d0, href_d1;
  logic        vs_rise, href_fall;
  logic [13:0] byte_cnt, ref_bytes;
  logic [12:0] line_cnt;
  logic        err_incons, err_odd;
  // set when a frame boundary cuts a line: its tail must not count as a line of the new frame
  logic        drop_line;
  logic [12:0] exp_h_q, exp_v_q;
  logic [15:0] skip_cnt;
  logic [12:0] rep_h;
  logic        rep_ok;

  assign vs_rise   = vsync_d0 & ~vsync_d1;
  assign href_fall = ~href_d0 & href_d1;

  // report values for the frame ending at the current vsync rise; href_d0 high means a truncated line
  always_comb begin
    rep_h  = (line_cnt == 13'd0) ? 13'd0 : ref_bytes[13:1];
    rep_ok = (rep_h == exp_h_q) && (line_cnt == exp_v_q) && !err_incons && !err_odd &&
             !href_d0 && (line_cnt != 13'd0);
  end

  // two-stage input registers for edge detection
  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      vsync_d0 <= 1'b0;
      vsync_d1 <= 1'b0;
      href_d0  <= 1'b0;
      href_d1  <= 1'b0;
    end else begin
      vsync_d0 <= cam_vsync;
      vsync_d1 <= vsync_d0;
      href_d0  <= cam_href;
      href_d1  <= href_d0;
    end
  end

  // expected size is captured at each frame start and applies to that frame
  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      exp_h_q <= 13'd0;
      exp_v_q <= 13'd0;
    end else if (vs_rise) begin
      exp_h_q <= exp_h_pixel;
      exp_v_q <= exp_v_pixel;
    end
  end

  // control FSM, line/byte measurement and per-frame reporting
  always_ff @(posedge cam_pclk) begin
    if (!rst_n) begin
      state        <= IDLE;
      skip_cnt     <= 16'd0;
      byte_cnt     <= 14'd0;
      ref_bytes    <= 14'd0;
      line_cnt     <= 13'd0;
      err_incons   <= 1'b0;
      err_odd      <= 1'b0;
      drop_line    <= 1'b0;
      meas_h_pixel <= 13'd0;
      meas_v_pixel <= 13'd0;
      meas_valid   <= 1'b0;
      size_ok      <= 1'b0;
      size_err     <= 1'b0;
      frame_cnt    <= 8'd0;
    end else if (!cfg_done) begin
      state      <= IDLE;
      skip_cnt   <= 16'd0;
      byte_cnt   <= 14'd0;
      ref_bytes  <= 14'd0;
      line_cnt   <= 13'd0;
      err_incons <= 1'b0;
      err_odd    <= 1'b0;
      drop_line  <= 1'b0;
      meas_valid <= 1'b0;
      size_ok    <= 1'b0;
      size_err   <= 1'b0;
      frame_cnt  <= 8'd0;
    end else begin
      meas_valid <= 1'b0;
      case (state)
        IDLE: begin
          state     <= SKIP;
          skip_cnt  <= 16'd0;
          byte_cnt  <= 14'd0;
          line_cnt  <= 13'd0;
          drop_line <= 1'b0;
        end
        SKIP, MEAS: begin
          if (vs_rise) begin
            if (state == SKIP) begin
              skip_cnt <= skip_cnt + 16'd1;
              if (skip_cnt + 16'd1 >= SKIP_LIM) state <= MEAS;
            end else begin
              meas_h_pixel <= rep_h;
              meas_v_pixel <= line_cnt;
              size_ok      <= rep_ok;
              size_err     <= !rep_ok;
              meas_valid   <= 1'b1;
              frame_cnt    <= frame_cnt + 8'd1;
            end
            byte_cnt   <= 14'd0;
            ref_bytes  <= 14'd0;
            line_cnt   <= 13'd0;
            err_incons <= 1'b0;
            err_odd    <= 1'b0;
            drop_line  <= href_d0;
          end else if (href_fall) begin
            byte_cnt  <= 14'd0;
            drop_line <= 1'b0;
            if (!drop_line) begin
              if (line_cnt != 13'h1fff) line_cnt <= line_cnt + 13'd1;
              if (line_cnt == 13'd0) ref_bytes <= byte_cnt;
              else if (byte_cnt != ref_bytes) err_incons <= 1'b1;
              if (byte_cnt[0]) err_odd <= 1'b1;
            end
          end else if (href_d0 && byte_cnt != 14'h3fff) begin
            byte_cnt <= byte_cnt + 14'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmos_size_check.sv
// tb/tb_cmos_size_check.sv - directed and randomized frame-size checks against a queue-based model
module tb_cmos_size_check;

  localparam int SKIP = 2;

  logic        cam_pclk = 1'b0;
  logic        rst_n, cfg_done, cam_vsync, cam_href;
  logic [12:0] exp_h_pixel, exp_v_pixel;
  logic [12:0] meas_h_pixel, meas_v_pixel;
  logic        meas_valid, size_ok, size_err;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int failures = 0;
  int mv_count = 0;
  int line_len[$];
  int rises = 0;
  int mframes = 0;
  int mexp_h = 0;
  int mexp_v = 0;
  int last_h = 0;
  int last_v = 0;

  always #5 cam_pclk = ~cam_pclk;

  cmos_size_check #(.SKIP_FRAMES(SKIP)) dut (
    .cam_pclk     (cam_pclk),
    .rst_n        (rst_n),
    .cfg_done     (cfg_done),
    .cam_vsync    (cam_vsync),
    .cam_href     (cam_href),
    .exp_h_pixel  (exp_h_pixel),
    .exp_v_pixel  (exp_v_pixel),
    .meas_h_pixel (meas_h_pixel),
    .meas_v_pixel (meas_v_pixel),
    .meas_valid   (meas_valid),
    .size_ok      (size_ok),
    .size_err     (size_err),
    .frame_cnt    (frame_cnt)
  );

  task automatic tick();
    @(posedge cam_pclk);
    #1;
    if (meas_valid) mv_count++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_meas_h"}, 32'(meas_h_pixel), 0);
    chk({tag, "_meas_v"}, 32'(meas_v_pixel), 0);
    chk({tag, "_valid"}, 32'(meas_valid), 0);
    chk({tag, "_ok"}, 32'(size_ok), 0);
    chk({tag, "_err"}, 32'(size_err), 0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
  endtask

  task automatic send_lines();
    foreach (line_len[i]) begin
      cam_href = 1'b1;
      repeat (line_len[i]) tick();
      cam_href = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end
    tick();
  endtask

  task automatic vsync_edge(input bit trunc);
    int n, eh, base, seen;
    bit cons, odd, eok;
    logic [12:0] oh, ov;
    logic ook, oerr;
    logic [7:0] ofc;
    oh = '0; ov = '0; ook = 1'b0; oerr = 1'b0; ofc = '0;
    if (trunc) begin
      cam_href = 1'b1;
      repeat (3) tick();
    end
    n    = line_len.size();
    eh   = (n == 0) ? 0 : line_len[0] / 2;
    cons = 1'b1;
    odd  = 1'b0;
    foreach (line_len[i]) begin
      if (line_len[i] != line_len[0]) cons = 1'b0;
      if (line_len[i] % 2 != 0) odd = 1'b1;
    end
    eok = (eh == mexp_h) && (n == mexp_v) && cons && !odd && !trunc && (n != 0);
    rises++;
    base = mv_count;
    seen = 0;
    cam_vsync = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (meas_valid && seen == 0) begin
        seen = i;
        oh = meas_h_pixel; ov = meas_v_pixel; ook = size_ok; oerr = size_err; ofc = frame_cnt;
      end
    end
    if (rises > SKIP) begin
      mframes = (mframes + 1) % 256;
      chk("report_latency", seen, 2);
      chk("pulse_count", mv_count - base, 1);
      chk("meas_h", 32'(oh), eh);
      chk("meas_v", 32'(ov), n);
      chk("size_ok", 32'(ook), 32'(eok));
      chk("size_err", 32'(oerr), 32'(!eok));
      chk("frame_cnt", 32'(ofc), mframes);
      last_h = eh;
      last_v = n;
    end else begin
      chk("skip_no_report", mv_count - base, 0);
    end
    mexp_h = exp_h_pixel;
    mexp_v = exp_v_pixel;
    line_len.delete();
    cam_vsync = 1'b0;
    if (trunc) begin
      tick();
      cam_href = 1'b0;
    end
    repeat (2) tick();
  endtask

  // drive one frame's lines, set the size expected for the next frame, then close with vsync
  task automatic frame(input int n, input int len, input int bad_idx, input int bad_len,
                       input bit trunc, input int next_h, input int next_v);
    for (int i = 0; i < n; i++) line_len.push_back((i == bad_idx) ? bad_len : len);
    send_lines();
    exp_h_pixel = 13'(next_h);
    exp_v_pixel = 13'(next_v);
    vsync_edge(trunc);
  endtask

  initial begin
    int cn, cl, nn, nl, bad, eh, ev, base;
    bit tr;
    rst_n = 1'b0; cfg_done = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0;
    exp_h_pixel = 13'd0; exp_v_pixel = 13'd0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    exp_h_pixel = 13'd6; exp_v_pixel = 13'd4;
    cfg_done = 1'b1;
    repeat (3) tick();
    vsync_edge(1'b0);
    frame(4, 12, -1, 0, 1'b0, 6, 4);
    frame(4, 12, -1, 0, 1'b0, 8, 5);
    frame(4, 16, -1, 0, 1'b0, 6, 4);
    frame(4, 12, 2, 13, 1'b0, 5, 3);
    frame(2, 10, -1, 0, 1'b1, 6, 4);

    nn = $urandom_range(1, 5);
    nl = 2 * $urandom_range(1, 8);
    for (int k = 0; k < 24; k++) begin
      cn = nn; cl = nl;
      nn = $urandom_range(1, 5);
      nl = 2 * $urandom_range(1, 8);
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(0, cn - 1) : -1;
      tr  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 2) != 0) begin
        eh = nl / 2; ev = nn;
      end else begin
        eh = $urandom_range(1, 8); ev = $urandom_range(1, 5);
      end
      frame(cn, cl, bad, cl + $urandom_range(1, 3), tr, eh, ev);
    end

    for (int i = 0; i < 2; i++) line_len.push_back(12);
    send_lines();
    cfg_done = 1'b0;
    tick();
    chk("cfgdrop_frame_cnt", 32'(frame_cnt), 0);
    chk("cfgdrop_ok", 32'(size_ok), 0);
    chk("cfgdrop_err", 32'(size_err), 0);
    chk("cfgdrop_valid", 32'(meas_valid), 0);
    chk("cfgdrop_h_held", 32'(meas_h_pixel), last_h);
    chk("cfgdrop_v_held", 32'(meas_v_pixel), last_v);
    cfg_done = 1'b1;
    rises = 0;
    mframes = 0;
    line_len.delete();
    exp_h_pixel = 13'd1; exp_v_pixel = 13'd1;
    repeat (2) tick();
    vsync_edge(1'b0);
    frame(1, 2, -1, 0, 1'b0, 1, 1);
    for (int k = 0; k < 257; k++) frame(1, 2, -1, 0, 1'b0, 1, 1);

    cam_href = 1'b1;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    chk_all_zero("midline_reset");
    base = mv_count;
    cam_href = 1'b0;
    cam_vsync = 1'b1;
    repeat (4) tick();
    chk("reset_no_report", mv_count - base, 0);
    cam_vsync = 1'b0;
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
